// File: rtl/y_sig_reader.sv
`default_nettype none
// ============================================================================
// Module   : y_sig_reader
// Purpose  : Samples the y bus for N cycles into a 32-bit MISR and counts
//            transitions; returns the result over a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module y_sig_reader #(
  parameter int          Y_W  = 10,
  parameter logic [31:0] SEED = 32'h0000_0000,
  parameter logic [31:0] POLY = 32'h04C1_1DB7
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [Y_W-1:0] y,
  input  logic           start,
  input  logic [15:0]    num_cycles,
  output logic           busy,
  output logic [31:0]    sig,
  output logic [15:0]    changes,
  output logic           sig_valid,
  input  logic           sig_ready
);

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    CAPTURE = 2'd1,
    HOLD    = 2'd2
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [31:0]     r_sig;
  logic [15:0]     r_changes;
  logic [Y_W-1:0]  r_prev_y;
  logic [15:0]     r_remaining;
  logic            r_busy;
  logic            r_sig_valid;
  logic [31:0]     w_y_ext;
  logic [31:0]     w_sig_nxt;

  assign w_y_ext   = 32'(y);
  assign w_sig_nxt = {r_sig[30:0], 1'b0} ^ (r_sig[31] ? POLY : 32'h0) ^ w_y_ext;

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE: begin
        if (start) begin
          w_state_nxt = (num_cycles == 16'd0) ? HOLD : CAPTURE;
        end
      end
      CAPTURE: begin
        // remaining==1 means this edge consumes the final sample
        if (r_remaining == 16'd1) begin
          w_state_nxt = HOLD;
        end
      end
      HOLD: begin
        if (sig_ready) begin
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_sig       <= SEED;
      r_changes   <= 16'd0;
      r_prev_y    <= '0;
      r_remaining <= 16'd0;
      r_busy      <= 1'b0;
      r_sig_valid <= 1'b0;
    end else begin
      r_state     <= w_state_nxt;
      r_busy      <= (w_state_nxt != IDLE);
      r_sig_valid <= (w_state_nxt == HOLD);
      case (r_state)
        IDLE: begin
          if (start) begin
            r_sig       <= SEED;
            r_changes   <= 16'd0;
            r_prev_y    <= y;
            r_remaining <= num_cycles;
          end
        end
        CAPTURE: begin
          r_sig       <= w_sig_nxt;
          r_prev_y    <= y;
          r_remaining <= r_remaining - 16'd1;
          if ((y != r_prev_y) && (r_changes != 16'hFFFF)) begin
            r_changes <= r_changes + 16'd1;
          end
        end
        default: begin
        end
      endcase
    end
  end

  assign busy      = r_busy;
  assign sig       = r_sig;
  assign changes   = r_changes;
  assign sig_valid = r_sig_valid;

endmodule
`default_nettype wire

// File: tb/tb_y_sig_reader.sv
`default_nettype none
// ============================================================================
// Module   : tb_y_sig_reader
// Purpose  : Scoreboard bench for y_sig_reader (MISR signature + change count).
// Revision : 1.0
// ============================================================================
module tb_y_sig_reader;

  localparam int          c_Y_W  = 10;
  localparam logic [31:0] c_SEED = 32'h0000_0000;
  localparam logic [31:0] c_POLY = 32'h04C1_1DB7;

  logic             clk;
  logic             rst_n;
  logic [c_Y_W-1:0] y;
  logic             start;
  logic [15:0]      num_cycles;
  logic             busy;
  logic [31:0]      sig;
  logic [15:0]      changes;
  logic             sig_valid;
  logic             sig_ready;

  int n_total;
  int n_pass;

  logic [47:0]      sb_q[$];
  logic [c_Y_W-1:0] stim_q[$];

  y_sig_reader #(.Y_W(c_Y_W), .SEED(c_SEED), .POLY(c_POLY)) u_dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .y          (y),
    .start      (start),
    .num_cycles (num_cycles),
    .busy       (busy),
    .sig        (sig),
    .changes    (changes),
    .sig_valid  (sig_valid),
    .sig_ready  (sig_ready)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  task automatic cyc();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [31:0] ref_step(input logic [31:0] s, input logic [c_Y_W-1:0] yv);
    logic [31:0] r;
    r = {s[30:0], 1'b0};
    if (s[31]) r = r ^ c_POLY;
    r = r ^ {22'd0, yv};
    return r;
  endfunction

  // Runs one capture using stim_q as the per-sample y values and y0 at start.
  task automatic do_run(input string name, input logic [c_Y_W-1:0] y0);
    logic [31:0]      e_sig;
    logic [15:0]      e_ch;
    logic [c_Y_W-1:0] prev;
    logic [47:0]      exp_v;
    int               n;
    int               waited;
    n     = stim_q.size();
    e_sig = c_SEED;
    e_ch  = 16'd0;
    prev  = y0;
    for (int i = 0; i < n; i++) begin
      e_sig = ref_step(e_sig, stim_q[i]);
      if (stim_q[i] != prev && e_ch != 16'hFFFF) e_ch = e_ch + 16'd1;
      prev = stim_q[i];
    end
    sb_q.push_back({e_sig, e_ch});

    y          = y0;
    num_cycles = 16'(n);
    start      = 1'b1;
    cyc();
    start = 1'b0;
    n_total++;
    if (busy !== 1'b1) $display("FAIL %s busy_after_start got=%b exp=1", name, busy);
    else n_pass++;
    for (int i = 0; i < n; i++) begin
      n_total++;
      if (sig_valid !== 1'b0) $display("FAIL %s early_valid cyc=%0d got=%b exp=0", name, i, sig_valid);
      else n_pass++;
      y = stim_q[i];
      cyc();
    end
    n_total++;
    if (sig_valid !== 1'b1) $display("FAIL %s valid_latency got=%b exp=1", name, sig_valid);
    else n_pass++;
    waited = 0;
    while (sig_valid !== 1'b1 && waited < 8) begin
      cyc();
      waited++;
    end
    exp_v = sb_q.pop_front();
    n_total++;
    if (sig !== exp_v[47:16]) $display("FAIL %s sig got=%h exp=%h", name, sig, exp_v[47:16]);
    else n_pass++;
    n_total++;
    if (changes !== exp_v[15:0]) $display("FAIL %s changes got=%0d exp=%0d", name, changes, exp_v[15:0]);
    else n_pass++;
    sig_ready = 1'b1;
    cyc();
    sig_ready = 1'b0;
    n_total++;
    if (sig_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL %s after_xfer valid=%b busy=%b exp=0/0", name, sig_valid, busy);
    else n_pass++;
    n_total++;
    if (sig !== exp_v[47:16]) $display("FAIL %s sig_kept got=%h exp=%h", name, sig, exp_v[47:16]);
    else n_pass++;
    stim_q.delete();
  endtask

  task automatic test_reset();
    rst_n = 1'b0;
    cyc();
    cyc();
    rst_n = 1'b1;
    n_total++;
    if (sig !== c_SEED || changes !== 16'd0 || sig_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL reset got sig=%h ch=%0d v=%b b=%b exp sig=%h ch=0 v=0 b=0",
               sig, changes, sig_valid, busy, c_SEED);
    else n_pass++;
  endtask

  task automatic test_basic();
    stim_q.push_back(10'h3FF);
    do_run("n1_3ff", 10'h000);
    stim_q.push_back(10'h001);
    stim_q.push_back(10'h002);
    do_run("n2_1_2", 10'h000);
    repeat (3) stim_q.push_back(10'h005);
    do_run("n3_hold5", 10'h005);
    repeat (3) stim_q.push_back(10'h005);
    do_run("n3_from0", 10'h000);
  endtask

  task automatic test_zero();
    do_run("n0", 10'h155);
  endtask

  task automatic test_hold_backpressure();
    logic [31:0] s0;
    logic [15:0] c0;
    y          = 10'h000;
    num_cycles = 16'd1;
    start      = 1'b1;
    cyc();
    start = 1'b0;
    y     = 10'h2A5;
    cyc();
    n_total++;
    if (sig_valid !== 1'b1 || sig !== 32'h0000_02A5 || changes !== 16'd1)
      $display("FAIL hold_setup got v=%b sig=%h ch=%0d exp v=1 sig=000002a5 ch=1", sig_valid, sig, changes);
    else n_pass++;
    s0 = 32'h0000_02A5;
    c0 = 16'd1;
    for (int i = 0; i < 10; i++) begin
      start      = i[0];
      num_cycles = 16'd3;
      y          = 10'(i * 37);
      cyc();
      n_total++;
      if (sig_valid !== 1'b1 || busy !== 1'b1 || sig !== s0 || changes !== c0)
        $display("FAIL hold_stable cyc=%0d got v=%b b=%b sig=%h ch=%0d exp v=1 b=1 sig=%h ch=%0d",
                 i, sig_valid, busy, sig, changes, s0, c0);
      else n_pass++;
    end
    start     = 1'b0;
    sig_ready = 1'b1;
    cyc();
    sig_ready = 1'b0;
    n_total++;
    if (sig_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL hold_release got v=%b b=%b exp=0/0", sig_valid, busy);
    else n_pass++;
    stim_q.push_back(10'h00F);
    stim_q.push_back(10'h0F0);
    do_run("after_hold", 10'h00F);
  endtask

  task automatic test_reset_mid_capture();
    sig_ready  = 1'b1;
    y          = 10'h001;
    num_cycles = 16'd100;
    start      = 1'b1;
    cyc();
    start = 1'b0;
    for (int i = 0; i < 50; i++) begin
      y = 10'($urandom);
      cyc();
    end
    rst_n = 1'b0;
    cyc();
    n_total++;
    if (sig !== c_SEED || changes !== 16'd0 || sig_valid !== 1'b0 || busy !== 1'b0)
      $display("FAIL mid_reset got sig=%h ch=%0d v=%b b=%b exp sig=%h ch=0 v=0 b=0",
               sig, changes, sig_valid, busy, c_SEED);
    else n_pass++;
    rst_n     = 1'b1;
    sig_ready = 1'b0;
    y         = 10'h000;
    cyc();
    n_total++;
    if (busy !== 1'b0 || sig_valid !== 1'b0)
      $display("FAIL post_reset_idle got b=%b v=%b exp=0/0", busy, sig_valid);
    else n_pass++;
  endtask

  task automatic test_feedback();
    stim_q.push_back(10'h001);
    repeat (32) stim_q.push_back(10'h000);
    do_run("n33_feedback", 10'h000);
  endtask

  task automatic test_random();
    for (int r = 0; r < 3; r++) begin
      int n;
      n = $urandom_range(5, 60);
      for (int i = 0; i < n; i++) stim_q.push_back(10'($urandom_range(0, 3)));
      do_run("random", 10'($urandom));
    end
  endtask

  initial begin
    n_total    = 0;
    n_pass     = 0;
    rst_n      = 1'b0;
    y          = '0;
    start      = 1'b0;
    num_cycles = 16'd0;
    sig_ready  = 1'b0;
    test_reset();
    test_basic();
    test_zero();
    test_hold_backpressure();
    test_reset_mid_capture();
    test_feedback();
    test_random();
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
`default_nettype wire
